// File: rtl/lsu_pic_responder.sv
// PIC register responder on the LSU picm_* port: register file, interrupt gateways and arbitration.
// Build option: define RV_PIC_GW_SYNC_EN for a 2-flop input synchronizer; RV_ASSERT_ON enables the port-usage assertion.
module lsu_pic_responder #(
    parameter int TOTAL_INT = 32,
    parameter int PIC_BITS  = 15,
    parameter int PRI_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 picm_rden,
    input  logic                 picm_mken,
    input  logic                 picm_wren,
    input  logic [31:0]          picm_addr,
    input  logic [31:0]          picm_wr_data,
    output logic [31:0]          picm_rd_data,
    input  logic [TOTAL_INT-1:0] extintsrc_req,
    input  logic [PRI_W-1:0]     meipt,
    output logic [7:0]           claimid,
    output logic [PRI_W-1:0]     pl,
    output logic                 mexintpend
);

    localparam int SW = (TOTAL_INT > 1) ? $clog2(TOTAL_INT) : 1;
    localparam int RW = PIC_BITS - 12;

    localparam logic [RW-1:0] REG_MEIPL  = RW'(0);
    localparam logic [RW-1:0] REG_MEIP   = RW'(1);
    localparam logic [RW-1:0] REG_MEIE   = RW'(2);
    localparam logic [RW-1:0] REG_CFG    = RW'(3);
    localparam logic [RW-1:0] REG_GWCTRL = RW'(4);
    localparam logic [RW-1:0] REG_GWCLR  = RW'(5);

    localparam logic [TOTAL_INT-1:0] SRC_MASK = {{(TOTAL_INT-1){1'b1}}, 1'b0};

    logic [PRI_W-1:0]     r_meipl [TOTAL_INT];
    logic [TOTAL_INT-1:0] r_meie;
    logic [TOTAL_INT-1:0] r_gw_pol;
    logic [TOTAL_INT-1:0] r_gw_type;
    logic                 r_mpiccfg;
    logic [TOTAL_INT-1:0] r_sync;
    logic [TOTAL_INT-1:0] r_prev;
    logic [TOTAL_INT-1:0] r_pend;
    logic [31:0]          r_rd_data;
    logic [7:0]           r_claimid;
    logic [PRI_W-1:0]     r_pl;
    logic                 r_mexintpend;

    logic [RW-1:0]        w_region;
    logic [9:0]           w_idx;
    logic [SW-1:0]        w_sid;
    logic                 w_src_ok;
    logic                 w_glob_ok;
    logic                 w_is_meipl, w_is_meip, w_is_meie, w_is_cfg, w_is_gwctrl, w_is_gwclr;
    logic                 w_wr_conflict;
    logic                 w_wr_ok;
    logic [31:0]          w_rd_val;
    logic [31:0]          w_mask_val;
    logic [TOTAL_INT-1:0] w_clr;
    logic [TOTAL_INT-1:0] w_s;
    logic [TOTAL_INT-1:0] w_pend_nxt;
    logic [PRI_W-1:0]     w_eff [TOTAL_INT];
    logic [PRI_W-1:0]     w_thr;
    logic [7:0]           w_best_id;
    logic [PRI_W-1:0]     w_best_eff;
    logic [PRI_W-1:0]     w_best_pl;
    logic                 w_unused;

    // Only the offset within the PIC window is decoded; base and byte-lane bits are don't-care.
    assign w_region  = picm_addr[PIC_BITS-1:12];
    assign w_idx     = picm_addr[11:2];
    assign w_sid     = w_idx[SW-1:0];
    assign w_src_ok  = (w_idx != '0) && (32'(w_idx) < 32'(TOTAL_INT));
    assign w_glob_ok = (w_idx == '0);
    assign w_unused  = ^{picm_addr[31:PIC_BITS], picm_addr[1:0], picm_wr_data[31:PRI_W]};

    assign w_is_meipl  = (w_region == REG_MEIPL)  && w_src_ok;
    assign w_is_meip   = (w_region == REG_MEIP)   && w_glob_ok;
    assign w_is_meie   = (w_region == REG_MEIE)   && w_src_ok;
    assign w_is_cfg    = (w_region == REG_CFG)    && w_glob_ok;
    assign w_is_gwctrl = (w_region == REG_GWCTRL) && w_src_ok;
    assign w_is_gwclr  = (w_region == REG_GWCLR)  && w_src_ok;

    // A write sharing a cycle with a read/mask is dropped so the DC1 response is never disturbed.
    assign w_wr_conflict = picm_wren && (picm_rden || picm_mken);
    assign w_wr_ok       = picm_wren && !w_wr_conflict;

    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        w_rd_val   = '0;
        w_mask_val = '0;
        if (w_is_meipl) begin
            w_rd_val   = 32'(r_meipl[w_sid]);
            w_mask_val = 32'({PRI_W{1'b1}});
        end
        if (w_is_meip) begin
            w_rd_val = 32'(r_pend);
        end
        if (w_is_meie) begin
            w_rd_val   = 32'(r_meie[w_sid]);
            w_mask_val = 32'h1;
        end
        if (w_is_cfg) begin
            w_rd_val   = 32'(r_mpiccfg);
            w_mask_val = 32'h1;
        end
        if (w_is_gwctrl) begin
            w_rd_val   = {30'b0, r_gw_type[w_sid], r_gw_pol[w_sid]};
            w_mask_val = 32'h3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the per-source register file is
    // reset entry by entry because arbitration reads every entry each cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < TOTAL_INT; i++) begin
                r_meipl[i] <= '0;
            end
            r_meie    <= '0;
            r_gw_pol  <= '0;
            r_gw_type <= '0;
            r_mpiccfg <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_ok && w_is_meipl)  r_meipl[w_sid]   <= picm_wr_data[PRI_W-1:0];
            if (w_wr_ok && w_is_meie)   r_meie[w_sid]    <= picm_wr_data[0];
            if (w_wr_ok && w_is_cfg)    r_mpiccfg        <= picm_wr_data[0];
            if (w_wr_ok && w_is_gwctrl) begin
                r_gw_pol[w_sid]  <= picm_wr_data[0];
                r_gw_type[w_sid] <= picm_wr_data[1];
            end
            if (picm_rden)      r_rd_data <= w_rd_val;
            else if (picm_mken) r_rd_data <= w_mask_val;
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_wr_ok && w_is_gwclr) w_clr[w_sid] = 1'b1;
    end

    // Edge gateways latch a rising (polarity-corrected) input until cleared; a new edge beats a clear.
    assign w_s        = r_sync ^ r_gw_pol;
    assign w_pend_nxt = SRC_MASK & ((r_gw_type & ((w_s & ~r_prev) | (r_pend & ~w_clr)))
                                    | (~r_gw_type & w_s));

`ifdef RV_PIC_GW_SYNC_EN
    logic [TOTAL_INT-1:0] r_sync_meta;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= extintsrc_req;
            r_sync      <= r_sync_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_sync <= '0;
        else        r_sync <= extintsrc_req;
    end
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= w_s;
            r_pend <= w_pend_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < TOTAL_INT; i++) begin
            w_eff[i] = r_mpiccfg ? ~r_meipl[i] : r_meipl[i];
        end
    end

    // Strict compare while scanning upward keeps the lowest ID on equal priority.
    always_comb begin
        w_best_id  = '0;
        w_best_eff = '0;
        w_best_pl  = '0;
        for (int i = 1; i < TOTAL_INT; i++) begin
            if (r_pend[i] && r_meie[i] && (w_eff[i] > w_best_eff)) begin
                w_best_id  = 8'(i);
                w_best_eff = w_eff[i];
                w_best_pl  = r_meipl[i];
            end
        end
    end

    assign w_thr = r_mpiccfg ? ~meipt : meipt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_claimid    <= '0;
            r_pl         <= '0;
            r_mexintpend <= 1'b0;
        end else begin
            r_claimid    <= w_best_id;
            r_pl         <= w_best_pl;
            r_mexintpend <= (w_best_eff > w_thr);
        end
    end

    assign picm_rd_data = r_rd_data;
    assign claimid      = r_claimid;
    assign pl           = r_pl;
    assign mexintpend   = r_mexintpend;

`ifdef RV_ASSERT_ON
    a_no_wr_with_rd: assert property (@(posedge clk) disable iff (!rst_l) !w_wr_conflict);
`endif

endmodule

// File: tb/tb_lsu_pic_responder.sv
// Directed bench for lsu_pic_responder: register-map vector table plus gateway/arbitration sequences.
module tb_lsu_pic_responder;

    localparam int TOTAL_INT = 32;
    localparam int PRI_W     = 4;
`ifdef RV_PIC_GW_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef enum logic [2:0] {OP_WR, OP_RD, OP_MK, OP_RM, OP_IDLE} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_l = 1'b0;
    logic                 picm_rden = 1'b0;
    logic                 picm_mken = 1'b0;
    logic                 picm_wren = 1'b0;
    logic [31:0]          picm_addr = '0;
    logic [31:0]          picm_wr_data = '0;
    logic [31:0]          picm_rd_data;
    logic [TOTAL_INT-1:0] extintsrc_req = '0;
    logic [PRI_W-1:0]     meipt = '0;
    logic [7:0]           claimid;
    logic [PRI_W-1:0]     pl;
    logic                 mexintpend;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    lsu_pic_responder #(.TOTAL_INT(TOTAL_INT), .PIC_BITS(15), .PRI_W(PRI_W)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .picm_rden    (picm_rden),
        .picm_mken    (picm_mken),
        .picm_wren    (picm_wren),
        .picm_addr    (picm_addr),
        .picm_wr_data (picm_wr_data),
        .picm_rd_data (picm_rd_data),
        .extintsrc_req(extintsrc_req),
        .meipt        (meipt),
        .claimid      (claimid),
        .pl           (pl),
        .mexintpend   (mexintpend)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input op_e op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string name);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e; v.name = name;
        vecs.push_back(v);
    endtask

    // All bus tasks start and end on a falling edge with the request lines idle.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        picm_wren = 1'b1; picm_addr = a; picm_wr_data = d;
        @(negedge clk);
        picm_wren = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic mk, output logic [31:0] d);
        picm_rden = !mk; picm_mken = mk; picm_addr = a;
        @(negedge clk);
        picm_rden = 1'b0; picm_mken = 1'b0;
        d = picm_rd_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;

        add(OP_RD,   32'h0000_3000, 0,            32'h0, "reset mpiccfg read");
        add(OP_WR,   32'h0000_0014, 32'hFFFFFFFA, 32'h0, "wr meipl5");
        add(OP_RD,   32'h0000_0014, 0,            32'hA, "meipl5 read");
        add(OP_MK,   32'h0000_0014, 0,            32'hF, "meipl5 mask");
        add(OP_IDLE, 32'h0,         0,            32'hF, "mask held");
        add(OP_RD,   32'hF00C_0017, 0,            32'hA, "base and low bits ignored");
        add(OP_RM,   32'h0000_0014, 0,            32'hA, "rden beats mken");
        add(OP_MK,   32'h0000_1000, 0,            32'h0, "meip mask");
        add(OP_MK,   32'h0000_2008, 0,            32'h1, "meie mask");
        add(OP_MK,   32'h0000_3000, 0,            32'h1, "mpiccfg mask");
        add(OP_MK,   32'h0000_400C, 0,            32'h3, "gwctrl mask");
        add(OP_MK,   32'h0000_5004, 0,            32'h0, "gwclr mask");
        add(OP_MK,   32'h0000_0000, 0,            32'h0, "S0 mask");
        add(OP_MK,   32'h0000_6000, 0,            32'h0, "unmapped mask");
        add(OP_MK,   32'h0000_3004, 0,            32'h0, "mpiccfg alias mask");
        add(OP_WR,   32'h0000_0000, 32'hF,        32'h0, "wr S0");
        add(OP_RD,   32'h0000_0000, 0,            32'h0, "S0 read");
        add(OP_WR,   32'h0000_0094, 32'h7,        32'h0, "wr S37");
        add(OP_RD,   32'h0000_0014, 0,            32'hA, "S37 no alias");
        add(OP_RD,   32'h0000_0094, 0,            32'h0, "S37 read");
        add(OP_WR,   32'h0000_5008, 32'hFFFFFFFF, 32'h0, "wr gwclr2");
        add(OP_RD,   32'h0000_5008, 0,            32'h0, "gwclr read");
        add(OP_WR,   32'h0000_2008, 32'hFFFFFFFF, 32'h0, "wr meie2");
        add(OP_RD,   32'h0000_2008, 0,            32'h1, "meie2 read");
        add(OP_WR,   32'h0000_400C, 32'hFFFFFFFF, 32'h0, "wr gwctrl3");
        add(OP_RD,   32'h0000_400C, 0,            32'h3, "gwctrl3 read");
        add(OP_WR,   32'h0000_400C, 32'h0,        32'h0, "wr gwctrl3 0");
        add(OP_RD,   32'h0000_400C, 0,            32'h0, "gwctrl3 cleared");
        add(OP_WR,   32'h0000_3000, 32'h1,        32'h0, "wr mpiccfg");
        add(OP_RD,   32'h0000_3000, 0,            32'h1, "mpiccfg read");
        add(OP_WR,   32'h0000_3000, 32'h0,        32'h0, "wr mpiccfg 0");
        add(OP_RD,   32'h0000_3000, 0,            32'h0, "mpiccfg cleared");
        add(OP_RD,   32'h0000_1000, 0,            32'h0, "meip idle");

        idle(2);
        rst_l = 1'b1;
        idle(1);
        check("reset rd_data", picm_rd_data, 32'h0);
        check("reset claimid", 32'(claimid), 32'h0);
        check("reset pl", 32'(pl), 32'h0);
        check("reset mexintpend", 32'(mexintpend), 32'h0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR: wr(vecs[i].addr, vecs[i].data);
                OP_RD: begin rd(vecs[i].addr, 1'b0, d); check(vecs[i].name, d, vecs[i].exp); end
                OP_MK: begin rd(vecs[i].addr, 1'b1, d); check(vecs[i].name, d, vecs[i].exp); end
                OP_RM: begin
                    picm_rden = 1'b1; picm_mken = 1'b1; picm_addr = vecs[i].addr;
                    @(negedge clk);
                    picm_rden = 1'b0; picm_mken = 1'b0;
                    check(vecs[i].name, picm_rd_data, vecs[i].exp);
                end
                default: begin idle(1); check(vecs[i].name, picm_rd_data, vecs[i].exp); end
            endcase
        end

        // Level source 3: pending two edges after input (one more when synchronized), claim one later.
        wr(32'h000C, 32'h5);
        wr(32'h200C, 32'h1);
        meipt = 4'd4;
        extintsrc_req[3] = 1'b1;
        idle(LAT + 1);
        check("S3 mexintpend early", 32'(mexintpend), 32'h0);
        check("S3 claimid early", 32'(claimid), 32'h0);
        rd(32'h1000, 1'b0, d);
        check("S3 meip", d, 32'h8);
        check("S3 claimid", 32'(claimid), 32'h3);
        check("S3 pl", 32'(pl), 32'h5);
        check("S3 mexintpend", 32'(mexintpend), 32'h1);
        meipt = 4'd5;
        idle(1);
        check("S3 meipt equal", 32'(mexintpend), 32'h0);
        check("S3 claim kept", 32'(claimid), 32'h3);

        meipt = 4'd4;
        extintsrc_req[3] = 1'b0;
        wr(32'h400C, 32'h1);
        idle(LAT + 3);
        check("S3 active-low claim", 32'(claimid), 32'h3);
        wr(32'h400C, 32'h0);
        idle(LAT + 3);
        check("S3 released claim", 32'(claimid), 32'h0);
        check("S3 released mexintpend", 32'(mexintpend), 32'h0);

        // Edge source 7: one-cycle pulse latched, cleared by gwclr, edge wins over same-cycle clear.
        wr(32'h001C, 32'h3);
        wr(32'h201C, 32'h1);
        wr(32'h401C, 32'h2);
        meipt = 4'd0;
        extintsrc_req[7] = 1'b1;
        idle(1);
        extintsrc_req[7] = 1'b0;
        idle(LAT + 3);
        rd(32'h1000, 1'b0, d);
        check("S7 edge latched", d, 32'h80);
        check("S7 claimid", 32'(claimid), 32'h7);
        wr(32'h501C, 32'h0);
        rd(32'h1000, 1'b0, d);
        check("S7 gwclr", d, 32'h0);
        extintsrc_req[7] = 1'b1;
        idle(LAT);
        extintsrc_req[7] = 1'b0;
        wr(32'h501C, 32'h0);
        idle(2);
        rd(32'h1000, 1'b0, d);
        check("S7 set beats clear", d, 32'h80);
        wr(32'h501C, 32'h0);
        idle(2);
        check("S7 claim cleared", 32'(claimid), 32'h0);

        // Arbitration: tie goes to lowest ID; reversed priority inverts both levels and threshold.
        wr(32'h0008, 32'h6);
        wr(32'h0024, 32'h6);
        wr(32'h2008, 32'h1);
        wr(32'h2024, 32'h1);
        extintsrc_req[2] = 1'b1;
        extintsrc_req[9] = 1'b1;
        idle(LAT + 3);
        check("tie claimid", 32'(claimid), 32'h2);
        check("tie pl", 32'(pl), 32'h6);
        check("tie mexintpend", 32'(mexintpend), 32'h1);
        wr(32'h0024, 32'h1);
        wr(32'h3000, 32'h1);
        idle(2);
        check("reverse claimid", 32'(claimid), 32'h9);
        check("reverse pl", 32'(pl), 32'h1);
        check("reverse thr0 mexintpend", 32'(mexintpend), 32'h0);
        meipt = 4'hF;
        idle(1);
        check("reverse thrF mexintpend", 32'(mexintpend), 32'h1);
        wr(32'h3000, 32'h0);
        extintsrc_req[2] = 1'b0;
        extintsrc_req[9] = 1'b0;
        meipt = 4'd0;
        idle(LAT + 3);
        check("arb released", 32'(claimid), 32'h0);

        // Illegal write alongside read or mask: response served, write dropped.
        rd(32'h2008, 1'b0, d);
        check("pre-conflict read", d, 32'h1);
        picm_rden = 1'b1; picm_wren = 1'b1; picm_addr = 32'h2004; picm_wr_data = 32'h1;
        #1;
        check("conflict flagged", 32'(dut.w_wr_conflict), 32'h1);
        @(negedge clk);
        picm_rden = 1'b0; picm_wren = 1'b0;
        check("conflict read data", picm_rd_data, 32'h0);
        rd(32'h2004, 1'b0, d);
        check("meie1 unchanged", d, 32'h0);
        picm_mken = 1'b1; picm_wren = 1'b1; picm_addr = 32'h0008; picm_wr_data = 32'hF;
        @(negedge clk);
        picm_mken = 1'b0; picm_wren = 1'b0;
        check("conflict mask data", picm_rd_data, 32'hF);
        rd(32'h0008, 1'b0, d);
        check("meipl2 unchanged", d, 32'h6);

        // Reset in the middle of a read: response discarded, claim dropped, nothing replayed.
        extintsrc_req[3] = 1'b1;
        idle(LAT + 3);
        check("pre-reset claimid", 32'(claimid), 32'h3);
        picm_rden = 1'b1; picm_addr = 32'h0014;
        #2 rst_l = 1'b0;
        @(negedge clk);
        picm_rden = 1'b0;
        check("reset rd discarded", picm_rd_data, 32'h0);
        check("reset claim dropped", 32'(claimid), 32'h0);
        rst_l = 1'b1;
        idle(1);
        check("no replay after reset", picm_rd_data, 32'h0);
        rd(32'h0014, 1'b0, d);
        check("meipl5 after reset", d, 32'h0);
        idle(LAT + 3);
        check("mexintpend after reset", 32'(mexintpend), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
